pc_fetch_sequencer: RTL and testbench

//   Owns the architectural PC and drives it into the branch unit's pc input.

---
 rtl/pc_fetch_sequencer.sv | 148 ++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the architectural PC, fetches each instruction over
// a req/ack handshake, holds it for decode/execute, then loads next_pc.
//
// state | meaning
// ------+--------------------------------------------------------------
// FETCH | imem_req asserted, waiting for imem_ack (bounded by timeout)
// EXEC  | instr valid and stable, waiting for exec_done
// HALT  | halt instruction retired, sticky until reset
// ERR   | fetch timeout or misaligned next_pc, sticky until reset
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic [31:0] next_pc,
  input  logic        halt,
  output logic        halted,
  output logic        fetch_err
);

  // Counter only ever reaches ACK_TIMEOUT-1, so clog2 bits are sufficient.
  localparam int CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  state_t           state_q, state_nx;
  logic [31:0]      pc_q, pc_nx;
  logic             req_q, req_nx;
  logic [31:0]      instr_q, instr_nx;
  logic             valid_q, valid_nx;
  logic             halted_q, halted_nx;
  logic             err_q, err_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;

  // State and all registered outputs; reset returns to FETCH with req low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      instr_q  <= 32'h0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_nx;
      pc_q     <= pc_nx;
      req_q    <= req_nx;
      instr_q  <= instr_nx;
      valid_q  <= valid_nx;
      halted_q <= halted_nx;
      err_q    <= err_nx;
      cnt_q    <= cnt_nx;
    end
  end

  // Next-state and next-output decode; everything holds unless a transition fires.
  always_comb begin
    state_nx  = state_q;
    pc_nx     = pc_q;
    req_nx    = req_q;
    instr_nx  = instr_q;
    valid_nx  = valid_q;
    halted_nx = halted_q;
    err_nx    = err_q;
    cnt_nx    = cnt_q;

    unique case (state_q)
      ST_FETCH: begin
        if (!req_q) begin
          // Only reachable right after reset: raise the request first, so an
          // ack seen before the request is out is not treated as a fetch.
          req_nx = 1'b1;
          cnt_nx = '0;
        end else if (imem_ack) begin
          // Ack wins even on the timeout cycle.
          instr_nx = imem_rdata;
          valid_nx = 1'b1;
          req_nx   = 1'b0;
          cnt_nx   = '0;
          state_nx = ST_EXEC;
        end else if (cnt_q == CNT_LAST) begin
          err_nx    = 1'b1;
          halted_nx = 1'b1;
          req_nx    = 1'b0;
          cnt_nx    = '0;
          state_nx  = ST_ERR;
        end else begin
          cnt_nx = cnt_q + CNT_W'(1);
        end
      end

      ST_EXEC: begin
        req_nx = 1'b0;
        if (exec_done) begin
          valid_nx = 1'b0;
          if (halt) begin
            halted_nx = 1'b1;
            state_nx  = ST_HALT;
          end else if (next_pc[1:0] != 2'b00) begin
            err_nx    = 1'b1;
            halted_nx = 1'b1;
            state_nx  = ST_ERR;
          end else begin
            pc_nx    = next_pc;
            req_nx   = 1'b1;
            cnt_nx   = '0;
            state_nx = ST_FETCH;
          end
        end
      end

      ST_HALT, ST_ERR: begin
        req_nx   = 1'b0;
        valid_nx = 1'b0;
      end

      default: begin
        state_nx = ST_ERR;
      end
    endcase
  end

  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign imem_req    = req_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer with ACK_TIMEOUT=4.
module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, imem_addr, imem_rdata, instr, next_pc;
  logic        imem_req, imem_ack, instr_valid, exec_done, halt, halted, fetch_err;

  int checks = 0;
  int errors = 0;

  pc_fetch_sequencer #(
    .RESET_PC   (32'h0000_0000),
    .ACK_TIMEOUT(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .exec_done  (exec_done),
    .next_pc    (next_pc),
    .halt       (halt),
    .halted     (halted),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Reset and release; on return the request is up at pc=0 with counter at 0.
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // One ack cycle followed by one exec_done cycle with the given next_pc.
  task automatic run_instr(input logic [31:0] word, input logic [31:0] npc);
    imem_ack = 1'b1; imem_rdata = word;
    tick();
    imem_ack = 1'b0;
    exec_done = 1'b1; next_pc = npc;
    tick();
    exec_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
    exec_done = 1'b0; next_pc = 32'h0; halt = 1'b0;
    tick();
    tick();
    chk1 ("rst_req",    imem_req,    1'b0);
    chk32("rst_pc",     pc,          32'h0);
    chk32("rst_instr",  instr,       32'h0);
    chk1 ("rst_valid",  instr_valid, 1'b0);
    chk1 ("rst_halted", halted,      1'b0);
    chk1 ("rst_err",    fetch_err,   1'b0);

    // T1: release, request rises on first edge; reset mid-FETCH drops it at once.
    rst = 1'b0;
    tick();
    chk1 ("t1_req_up",  imem_req,  1'b1);
    chk32("t1_addr",    imem_addr, 32'h0);
    tick();
    chk1 ("t1_req_hold", imem_req, 1'b1);
    rst = 1'b1;
    #1;
    chk1 ("t1_async_req", imem_req, 1'b0);
    chk32("t1_async_pc",  pc,       32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk1 ("t1_req_again", imem_req, 1'b1);

    // T2: sequential fetch and pc+4.
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    chk32("t2_instr",  instr,       32'h1234_5678);
    chk1 ("t2_valid",  instr_valid, 1'b1);
    chk1 ("t2_req_lo", imem_req,    1'b0);
    tick();
    chk32("t2_instr_stable", instr,       32'h1234_5678);
    chk1 ("t2_valid_stable", instr_valid, 1'b1);
    exec_done = 1'b1; next_pc = 32'h0000_0004;
    tick();
    exec_done = 1'b0;
    chk32("t2_pc",    pc,          32'h0000_0004);
    chk32("t2_addr",  imem_addr,   32'h0000_0004);
    chk1 ("t2_req",   imem_req,    1'b1);
    chk1 ("t2_valid_lo", instr_valid, 1'b0);

    // T3: branch and wrap from the top of the address space.
    run_instr(32'h0000_0013, 32'h0000_0100);
    chk32("t3_pc_branch", pc, 32'h0000_0100);
    run_instr(32'h0000_0013, 32'hFFFF_FFFC);
    chk32("t3_pc_top", pc, 32'hFFFF_FFFC);
    run_instr(32'h0000_0013, 32'h0000_0000);
    chk32("t3_pc_wrap", pc,        32'h0000_0000);
    chk1 ("t3_err",     fetch_err, 1'b0);
    chk1 ("t3_req",     imem_req,  1'b1);

    // T4: misaligned target; pc held and the block goes deaf.
    run_instr(32'h0000_0013, 32'h0000_0006);
    chk1 ("t4_err",    fetch_err,   1'b1);
    chk1 ("t4_halted", halted,      1'b1);
    chk32("t4_pc",     pc,          32'h0);
    chk1 ("t4_req",    imem_req,    1'b0);
    chk1 ("t4_valid",  instr_valid, 1'b0);
    run_instr(32'h0000_0099, 32'h0000_0008);
    chk32("t4_pc_ignored",  pc,          32'h0);
    chk1 ("t4_req_ignored", imem_req,    1'b0);
    chk1 ("t4_valid_ign",   instr_valid, 1'b0);
    chk1 ("t4_err_sticky",  fetch_err,   1'b1);

    // T5a: no ack; error on the 4th fetch cycle.
    do_reset();
    tick();
    chk1("t5_err_c1", fetch_err, 1'b0);
    tick();
    chk1("t5_err_c2", fetch_err, 1'b0);
    tick();
    chk1("t5_err_c3", fetch_err, 1'b0);
    chk1("t5_req_c3", imem_req,  1'b1);
    tick();
    chk1("t5_err",    fetch_err, 1'b1);
    chk1("t5_halted", halted,    1'b1);
    chk1("t5_req_lo", imem_req,  1'b0);

    // T5b: ack arriving on the 4th cycle beats the timeout.
    do_reset();
    tick();
    tick();
    tick();
    imem_ack = 1'b1; imem_rdata = 32'hCAFE_0004;
    tick();
    imem_ack = 1'b0;
    chk1 ("t5b_err",   fetch_err,   1'b0);
    chk1 ("t5b_valid", instr_valid, 1'b1);
    chk32("t5b_instr", instr,       32'hCAFE_0004);
    chk1 ("t5b_halted", halted,     1'b0);

    // T6: halt from EXEC; pc unchanged, no error.
    exec_done = 1'b1; halt = 1'b1; next_pc = 32'h0000_0008;
    tick();
    exec_done = 1'b0; halt = 1'b0;
    chk1 ("t6_halted", halted,      1'b1);
    chk1 ("t6_err",    fetch_err,   1'b0);
    chk32("t6_pc",     pc,          32'h0);
    chk1 ("t6_req",    imem_req,    1'b0);
    chk1 ("t6_valid",  instr_valid, 1'b0);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk1 ("t6_req_sticky", imem_req, 1'b0);

    // Priority: halt beats a misaligned next_pc in the same cycle.
    do_reset();
    imem_ack = 1'b1; imem_rdata = 32'h0000_0001;
    tick();
    imem_ack = 1'b0;
    exec_done = 1'b1; halt = 1'b1; next_pc = 32'h0000_0002;
    tick();
    exec_done = 1'b0; halt = 1'b0;
    chk1 ("prio_halted", halted,    1'b1);
    chk1 ("prio_err",    fetch_err, 1'b0);
    chk32("prio_pc",     pc,        32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
